// File: rtl/mem_wb_pipe_if.sv
// MEM->WB bus bundle: per-channel write-back buses on both sides of the pipeline register.
// Optional HI/LO transfer fields exist only when MEM_WB_HILO_EN is defined.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NCH    = 1
);
  logic                    mem_valid;
  logic [NCH*ADDR_W-1:0]   mem_wd;
  logic [NCH-1:0]          mem_wreg;
  logic [NCH*DATA_W-1:0]   mem_wdata;
  logic                    wb_valid;
  logic [NCH*ADDR_W-1:0]   wb_wd;
  logic [NCH-1:0]          wb_wreg;
  logic [NCH*DATA_W-1:0]   wb_wdata;
`ifdef MEM_WB_HILO_EN
  logic                    mem_whilo;
  logic [DATA_W-1:0]       mem_hi;
  logic [DATA_W-1:0]       mem_lo;
  logic                    wb_whilo;
  logic [DATA_W-1:0]       wb_hi;
  logic [DATA_W-1:0]       wb_lo;

  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );
  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );
`else
  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata,
    input  wb_valid, wb_wd, wb_wreg, wb_wdata
  );
  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata,
    output wb_valid, wb_wd, wb_wreg, wb_wdata
  );
`endif
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with NCH write channels, stall/flush handling and perf counters.
// Define MEM_WB_HILO_EN to also carry the HI/LO write-back fields.
module mem_wb_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NCH     = 1,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  mem_wb_pipe_if.slave       bus,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam logic [1:0]       ACT_ADVANCE = 2'd0;
  localparam logic [1:0]       ACT_BUBBLE  = 2'd1;
  localparam logic [1:0]       ACT_HOLD    = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

  logic                  stall_here_s;
  logic                  stall_next_s;
  logic                  stall_unused_s;
  logic [1:0]            act_s;
  logic [NCH-1:0]        wreg_keep_s;

  logic                  wb_valid_r;
  logic [NCH*ADDR_W-1:0] wb_wd_r;
  logic [NCH-1:0]        wb_wreg_r;
  logic [NCH*DATA_W-1:0] wb_wdata_r;
  logic [CNT_W-1:0]      retire_cnt_r;
  logic [CNT_W-1:0]      stall_cnt_r;

  assign stall_here_s   = stall[STAGE];
  assign stall_next_s   = stall[STAGE+1];
  assign stall_unused_s = ^stall;

  // Decide what the register does this cycle: flush beats stall, a stalled WB holds.
  always_comb begin
    act_s = ACT_ADVANCE;
    if (flush) begin
      act_s = ACT_BUBBLE;
    end else if (stall_here_s) begin
      if (stall_next_s) begin
        act_s = ACT_HOLD;
      end else begin
        act_s = ACT_BUBBLE;
      end
    end else begin
      act_s = ACT_ADVANCE;
    end
  end

  // Effective write enables: drop r0 writes and older channels shadowed by a younger same-address write.
  always_comb begin
    wreg_keep_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.mem_valid && bus.mem_wreg[i] && (bus.mem_wd[i*ADDR_W +: ADDR_W] != '0)) begin
        wreg_keep_s[i] = 1'b1;
        for (int j = i + 1; j < NCH; j++) begin
          if (bus.mem_wreg[j] && (bus.mem_wd[j*ADDR_W +: ADDR_W] == bus.mem_wd[i*ADDR_W +: ADDR_W])) begin
            wreg_keep_s[i] = 1'b0;
          end else begin
            wreg_keep_s[i] = wreg_keep_s[i];
          end
        end
      end else begin
        wreg_keep_s[i] = 1'b0;
      end
    end
  end

  // Write-back channel register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      wb_wd_r    <= '0;
      wb_wreg_r  <= '0;
      wb_wdata_r <= '0;
    end else begin
      case (act_s)
        ACT_ADVANCE: begin
          wb_valid_r <= bus.mem_valid;
          wb_wd_r    <= bus.mem_wd;
          wb_wreg_r  <= wreg_keep_s;
          wb_wdata_r <= bus.mem_wdata;
        end
        ACT_HOLD: begin
          wb_valid_r <= wb_valid_r;
          wb_wd_r    <= wb_wd_r;
          wb_wreg_r  <= wb_wreg_r;
          wb_wdata_r <= wb_wdata_r;
        end
        default: begin
          wb_valid_r <= 1'b0;
          wb_wd_r    <= '0;
          wb_wreg_r  <= '0;
          wb_wdata_r <= '0;
        end
      endcase
    end
  end

  // Perf counters; stalled cycles count even when a flush is also present.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_r <= '0;
      stall_cnt_r  <= '0;
    end else begin
      if ((act_s == ACT_ADVANCE) && bus.mem_valid) begin
        retire_cnt_r <= retire_cnt_r + CNT_ONE;
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
      if (stall_here_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.wb_valid = wb_valid_r;
  assign bus.wb_wd    = wb_wd_r;
  assign bus.wb_wreg  = wb_wreg_r;
  assign bus.wb_wdata = wb_wdata_r;
  assign retire_cnt   = retire_cnt_r;
  assign stall_cnt    = stall_cnt_r;

`ifdef MEM_WB_HILO_EN
  logic              wb_whilo_r;
  logic [DATA_W-1:0] wb_hi_r;
  logic [DATA_W-1:0] wb_lo_r;

  // HI/LO transfer register, same advance/bubble/hold behaviour as the channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_whilo_r <= 1'b0;
      wb_hi_r    <= '0;
      wb_lo_r    <= '0;
    end else begin
      case (act_s)
        ACT_ADVANCE: begin
          wb_whilo_r <= bus.mem_whilo & bus.mem_valid;
          wb_hi_r    <= bus.mem_hi;
          wb_lo_r    <= bus.mem_lo;
        end
        ACT_HOLD: begin
          wb_whilo_r <= wb_whilo_r;
          wb_hi_r    <= wb_hi_r;
          wb_lo_r    <= wb_lo_r;
        end
        default: begin
          wb_whilo_r <= 1'b0;
          wb_hi_r    <= '0;
          wb_lo_r    <= '0;
        end
      endcase
    end
  end

  assign bus.wb_whilo = wb_whilo_r;
  assign bus.wb_hi    = wb_hi_r;
  assign bus.wb_lo    = wb_lo_r;
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (NCH=2, CNT_W=4); HI/LO checks run when MEM_WB_HILO_EN is defined.
module tb_mem_wb_pipe;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NC  = 2;
  localparam int SW  = 6;
  localparam int STG = 4;
  localparam int CW  = 4;
  localparam logic [CW-1:0] ONE = CW'(1'b1);

  typedef struct packed {
    logic             valid;
    logic [NC*AW-1:0] wd;
    logic [NC-1:0]    wreg;
    logic [NC*DW-1:0] wdata;
    logic [CW-1:0]    ret;
    logic [CW-1:0]    stl;
    logic             whilo;
    logic [DW-1:0]    hi;
    logic [DW-1:0]    lo;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush;
  logic [CW-1:0] retire_cnt;
  logic [CW-1:0] stall_cnt;

  obs_t mdl;
  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_wb_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC)) bus ();

  mem_wb_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .NCH(NC), .STALL_W(SW), .STAGE(STG), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, push the expected WB state, then wait past the edge.
  task automatic step(input logic r, input logic f, input logic [SW-1:0] st, input logic mv,
                      input logic [NC*AW-1:0] wd, input logic [NC-1:0] wreg,
                      input logic [NC*DW-1:0] wdata, input logic whl,
                      input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    logic [NC-1:0] nw;
    logic [AW-1:0] a;
    logic          keep;
    rst = r; flush = f; stall = st;
    bus.mem_valid = mv; bus.mem_wd = wd; bus.mem_wreg = wreg; bus.mem_wdata = wdata;
`ifdef MEM_WB_HILO_EN
    bus.mem_whilo = whl; bus.mem_hi = hi; bus.mem_lo = lo;
`else
    whl = 1'b0; hi = '0; lo = '0;
`endif
    if (r) begin
      mdl = '0;
    end else begin
      if (st[STG]) mdl.stl = mdl.stl + ONE;
      if (f || (st[STG] && !st[STG+1])) begin
        mdl.valid = 1'b0; mdl.wd = '0; mdl.wreg = '0; mdl.wdata = '0;
        mdl.whilo = 1'b0; mdl.hi = '0; mdl.lo = '0;
      end else if (!st[STG]) begin
        nw = '0;
        for (int i = 0; i < NC; i++) begin
          a = wd[i*AW +: AW];
          keep = mv && wreg[i] && (a != '0);
          for (int j = i + 1; j < NC; j++)
            if (wreg[j] && (wd[j*AW +: AW] == a)) keep = 1'b0;
          nw[i] = keep;
        end
        mdl.valid = mv; mdl.wd = wd; mdl.wreg = nw; mdl.wdata = wdata;
        mdl.whilo = whl && mv; mdl.hi = hi; mdl.lo = lo;
        if (mv) mdl.ret = mdl.ret + ONE;
      end
    end
    sb_q.push_back(mdl);
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.valid = bus.wb_valid; o.wd = bus.wb_wd; o.wreg = bus.wb_wreg; o.wdata = bus.wb_wdata;
    o.ret = retire_cnt; o.stl = stall_cnt;
`ifdef MEM_WB_HILO_EN
    o.whilo = bus.wb_whilo; o.hi = bus.wb_hi; o.lo = bus.wb_lo;
`else
    o.whilo = 1'b0; o.hi = '0; o.lo = '0;
`endif
    return o;
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    step(1'b1, 1'b0, 6'b0, 1'b1, {5'd0, 5'd5}, 2'b01, {32'h0, 32'hDEAD_BEEF}, 1'b1, 32'h1, 32'h2);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_sb got=%h exp=%h", got, exp); end
    checks++; if (got !== obs_t'(0)) begin failures++; $display("FAIL reset_zero got=%h exp=0", got); end
    step(1'b0, 1'b0, 6'b0, 1'b1, {5'd0, 5'd5}, 2'b01, {32'h0, 32'hDEAD_BEEF}, 1'b1, 32'h1, 32'h2);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL release_sb got=%h exp=%h", got, exp); end
    checks++;
    if (got.wd !== 10'd5 || got.wdata !== 64'hDEAD_BEEF || got.valid !== 1'b1 || got.ret !== 4'd1) begin
      failures++; $display("FAIL release_const got=%h", got);
    end
  endtask

  task automatic test_hold_bubble();
    obs_t got, exp;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 6'b110000, 1'b1, {5'(k + 10), 5'(k + 20)}, 2'b11, {32'(k), 32'h1234_0000 + 32'(k)},
           1'b1, 32'h5, 32'h6);
      got = sample(); exp = sb_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL hold_sb[%0d] got=%h exp=%h", k, got, exp); end
    end
    checks++;
    if (got.wd !== 10'd5 || got.wdata !== 64'hDEAD_BEEF || got.valid !== 1'b1 || got.wreg !== 2'b01
        || got.stl !== 4'd3 || got.ret !== 4'd1) begin
      failures++; $display("FAIL hold_const got=%h", got);
    end
    step(1'b0, 1'b0, 6'b010000, 1'b1, {5'd9, 5'd8}, 2'b11, {32'h7, 32'h8}, 1'b1, 32'h5, 32'h6);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL bubble_sb got=%h exp=%h", got, exp); end
    checks++;
    if (got.wreg !== 2'b00 || got.wd !== 10'd0 || got.valid !== 1'b0 || got.ret !== 4'd1 || got.stl !== 4'd4) begin
      failures++; $display("FAIL bubble_const got=%h", got);
    end
  endtask

  task automatic test_flush();
    obs_t got, exp;
    step(1'b0, 1'b0, 6'b0, 1'b1, {5'd0, 5'd9}, 2'b01, {32'h0, 32'h99}, 1'b0, 32'h0, 32'h0);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL pre_flush_sb got=%h exp=%h", got, exp); end
    step(1'b0, 1'b1, 6'b0, 1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h77}, 1'b1, 32'h3, 32'h4);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL flush_sb got=%h exp=%h", got, exp); end
    checks++;
    if (got.valid !== 1'b0 || got.wreg !== 2'b00 || got.ret !== 4'd2) begin
      failures++; $display("FAIL flush_const got=%h", got);
    end
    step(1'b0, 1'b1, 6'b110000, 1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h77}, 1'b0, 32'h0, 32'h0);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL flush_hold_sb got=%h exp=%h", got, exp); end
    checks++;
    if (got.valid !== 1'b0 || got.stl !== 4'd5 || got.ret !== 4'd2) begin
      failures++; $display("FAIL flush_hold_const got=%h", got);
    end
    step(1'b1, 1'b1, 6'b110000, 1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h77}, 1'b0, 32'h0, 32'h0);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL rst_flush_sb got=%h exp=%h", got, exp); end
    checks++;
    if (got.ret !== 4'd0 || got.stl !== 4'd0) begin failures++; $display("FAIL rst_flush_cnt got=%h", got); end
  endtask

  task automatic test_conflict();
    obs_t got, exp;
    logic [NC-1:0] want [3] = '{2'b10, 2'b01, 2'b00};
    logic [NC*AW-1:0] wds [3] = '{{5'd3, 5'd3}, {5'd0, 5'd3}, {5'd3, 5'd3}};
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 6'b0, (k != 2), wds[k], 2'b11, {32'd2, 32'd1}, 1'b0, 32'h0, 32'h0);
      got = sample(); exp = sb_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL conflict_sb[%0d] got=%h exp=%h", k, got, exp); end
      checks++;
      if (got.wreg !== want[k]) begin
        failures++; $display("FAIL conflict_wreg[%0d] got=%b exp=%b", k, got.wreg, want[k]);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    step(1'b1, 1'b0, 6'b0, 1'b0, '0, '0, '0, 1'b0, 32'h0, 32'h0);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL wrap_rst_sb got=%h exp=%h", got, exp); end
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 1'b0, 6'b0, 1'b1, {5'd1, 5'(k)}, 2'b01, {32'h0, 32'(k)}, 1'b0, 32'h0, 32'h0);
      got = sample(); exp = sb_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL wrap_sb[%0d] got=%h exp=%h", k, got, exp); end
    end
    checks++; if (got.ret !== 4'd1) begin failures++; $display("FAIL wrap_ret got=%0d exp=1", got.ret); end
  endtask

`ifdef MEM_WB_HILO_EN
  task automatic test_hilo();
    obs_t got, exp;
    step(1'b0, 1'b0, 6'b0, 1'b1, {5'd0, 5'd4}, 2'b01, {32'h0, 32'h44}, 1'b1, 32'h1, 32'h2);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL hilo_sb got=%h exp=%h", got, exp); end
    checks++;
    if (got.whilo !== 1'b1 || got.hi !== 32'h1 || got.lo !== 32'h2) begin
      failures++; $display("FAIL hilo_const got=%b/%h/%h", got.whilo, got.hi, got.lo);
    end
    step(1'b0, 1'b0, 6'b0, 1'b0, {5'd0, 5'd4}, 2'b01, {32'h0, 32'h44}, 1'b1, 32'h1, 32'h2);
    got = sample(); exp = sb_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL hilo_inv_sb got=%h exp=%h", got, exp); end
    checks++; if (got.whilo !== 1'b0) begin failures++; $display("FAIL hilo_inv got=%b exp=0", got.whilo); end
  endtask
`endif

  task automatic test_back_to_back();
    obs_t got, exp;
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 6'($urandom), 1'($urandom),
           {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom), {$urandom, $urandom},
           1'($urandom), $urandom, $urandom);
      got = sample(); exp = sb_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL b2b_sb[%0d] got=%h exp=%h", k, got, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    mdl = '0;
    test_reset();
    test_hold_bubble();
    test_flush();
    test_conflict();
    test_wrap();
`ifdef MEM_WB_HILO_EN
    test_hilo();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
